// File: rtl/bist_pkg.sv
// bist_pkg: checker state type and default BIST geometry shared with pattern generators
package bist_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} chk_state_t;
  localparam int DEF_MAX_ADDR      = 31;
  localparam int DEF_DATA_WIDTH    = 8;
  localparam int DEF_READ_LATENCY  = 1;
  localparam int DEF_ERR_CNT_WIDTH = 16;
endpackage

// File: rtl/bist_delay_line.sv
// bist_delay_line: fixed-depth shift register with synchronous clear
module bist_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [DEPTH-1:0][WIDTH-1:0] sr;
  always_ff @(posedge clk) begin
    if (rst) sr <= '0;
    else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end
  assign q = sr[DEPTH-1];
endmodule

// File: rtl/bist_checker.sv
// bist_checker: compares delayed expected words against SRAM read data, logs first failure
module bist_checker import bist_pkg::*; #(
  parameter  int MAX_ADDR      = DEF_MAX_ADDR,
  parameter  int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter  int READ_LATENCY  = DEF_READ_LATENCY,
  parameter  int ERR_CNT_WIDTH = DEF_ERR_CNT_WIDTH,
  localparam int ADDR_WIDTH    = $clog2(MAX_ADDR + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     pg_re,
  input  logic [ADDR_WIDTH-1:0]    pg_addr,
  input  logic [DATA_WIDTH-1:0]    pg_check,
  input  logic                     pg_done,
  input  logic [DATA_WIDTH-1:0]    sram_dout,
  output logic                     done,
  output logic                     fail,
  output logic [ERR_CNT_WIDTH-1:0] err_count,
  output logic [ADDR_WIDTH-1:0]    first_fail_addr,
  output logic [DATA_WIDTH-1:0]    first_fail_expected,
  output logic [DATA_WIDTH-1:0]    first_fail_actual
);
  localparam int EW = 1 + ADDR_WIDTH + DATA_WIDTH;
  chk_state_t state, state_nxt;
  logic [1:0] drain_cnt;
  logic push, chk_valid, mismatch;
  logic [ADDR_WIDTH-1:0] chk_addr;
  logic [DATA_WIDTH-1:0] chk_exp;
  assign push = state == RUN && en && pg_re;
  bist_delay_line #(.DEPTH(READ_LATENCY), .WIDTH(EW)) u_dly (
    .clk (clk),
    .rst (rst),
    .d   ({push, pg_addr, pg_check}),
    .q   ({chk_valid, chk_addr, chk_exp})
  );
  assign mismatch = chk_valid && (state == RUN || state == DRAIN) && chk_exp != sram_dout;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= state == DRAIN ? drain_cnt + 2'd1 : '0;
    end
  end
  // DRAIN lasts exactly READ_LATENCY edges so the last pushed read is still compared
  always_comb begin
    state_nxt = state == IDLE  ? (en ? RUN : IDLE) :
                state == RUN   ? (pg_done ? DRAIN : RUN) :
                state == DRAIN ? (drain_cnt == 2'(READ_LATENCY - 1) ? DONE : DRAIN) : DONE;
  end
  always_comb begin
    done = state == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      fail                <= 1'b0;
      err_count           <= '0;
      first_fail_addr     <= '0;
      first_fail_expected <= '0;
      first_fail_actual   <= '0;
    end else if (mismatch) begin
      if (~&err_count) err_count <= err_count + ERR_CNT_WIDTH'(1);
      if (!fail) begin
        fail                <= 1'b1;
        first_fail_addr     <= chk_addr;
        first_fail_expected <= chk_exp;
        first_fail_actual   <= sram_dout;
      end
    end
  end
endmodule

// File: tb/tb_bist_checker.sv
// tb_bist_checker: two checker instances (latency 1/16-bit count, latency 3/4-bit count) vs a transaction model
module tb_bist_checker;
  logic clk = 0;
  logic rst, en, pg_re, pg_done;
  logic [4:0] pg_addr;
  logic [7:0] pg_check;
  logic [7:0] sd [2];
  logic [7:0] past [3] = '{8'h00, 8'h00, 8'h00};
  logic done0, fail0, done1, fail1;
  logic [15:0] err0;
  logic [3:0] err1;
  logic [4:0] ffa0, ffa1;
  logic [7:0] ffe0, ffx0, ffe1, ffx1;
  int total = 0, bad = 0;
  logic chk_on = 0;
  typedef struct {int k; int a; logic [7:0] e; int due;} ent_t;
  ent_t q[$];
  int lat [2] = '{1, 3};
  int maxc [2] = '{65535, 15};
  int m_n = 0, m_dedge = -1;
  bit m_armed = 0;
  int m_err [2], m_fa [2], m_fe [2], m_fx [2];
  bit m_fail [2];

  always #5 clk = ~clk;

  bist_checker dut0 (
    .clk(clk), .rst(rst), .en(en), .pg_re(pg_re), .pg_addr(pg_addr), .pg_check(pg_check),
    .pg_done(pg_done), .sram_dout(sd[0]), .done(done0), .fail(fail0), .err_count(err0),
    .first_fail_addr(ffa0), .first_fail_expected(ffe0), .first_fail_actual(ffx0)
  );
  bist_checker #(.READ_LATENCY(3), .ERR_CNT_WIDTH(4)) dut1 (
    .clk(clk), .rst(rst), .en(en), .pg_re(pg_re), .pg_addr(pg_addr), .pg_check(pg_check),
    .pg_done(pg_done), .sram_dout(sd[1]), .done(done1), .fail(fail1), .err_count(err1),
    .first_fail_addr(ffa1), .first_fail_expected(ffe1), .first_fail_actual(ffx1)
  );

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reads are due lat[k] edges after being accepted; all due reads are compared, then new ones accepted.
  task automatic model_edge();
    int k;
    m_n++;
    if (rst) begin
      q.delete();
      m_armed = 0;
      m_dedge = -1;
      for (int j = 0; j < 2; j++) begin
        m_err[j] = 0; m_fail[j] = 0; m_fa[j] = 0; m_fe[j] = 0; m_fx[j] = 0;
      end
    end else begin
      for (int i = 0; i < q.size(); ) begin
        if (q[i].due == m_n) begin
          k = q[i].k;
          if (sd[k] != q[i].e) begin
            if (m_err[k] < maxc[k]) m_err[k]++;
            if (!m_fail[k]) begin
              m_fail[k] = 1; m_fa[k] = q[i].a; m_fe[k] = int'(q[i].e); m_fx[k] = int'(sd[k]);
            end
          end
          q.delete(i);
        end else i++;
      end
      if (m_armed && m_dedge < 0) begin
        if (en && pg_re)
          for (int j = 0; j < 2; j++) q.push_back('{j, int'(pg_addr), pg_check, m_n + lat[j]});
        if (pg_done) m_dedge = m_n;
      end
      if (!m_armed && en) m_armed = 1;
    end
  endtask

  function automatic int m_done(input int k);
    return (m_dedge >= 0 && m_n >= m_dedge + lat[k]) ? 1 : 0;
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      chk("done0", int'(done0), m_done(0));
      chk("fail0", int'(fail0), int'(m_fail[0]));
      chk("err0", int'(err0), m_err[0]);
      chk("ffa0", int'(ffa0), m_fa[0]);
      chk("ffe0", int'(ffe0), m_fe[0]);
      chk("ffx0", int'(ffx0), m_fx[0]);
      chk("done1", int'(done1), m_done(1));
      chk("fail1", int'(fail1), int'(m_fail[1]));
      chk("err1", int'(err1), m_err[1]);
      chk("ffa1", int'(ffa1), m_fa[1]);
      chk("ffe1", int'(ffe1), m_fe[1]);
      chk("ffx1", int'(ffx1), m_fx[1]);
    end
  end

  // data is what the SRAM returns for this cycle's address, read_latency edges later
  task automatic step(input logic r, input logic e, input logic re, input int a,
                      input logic [7:0] c, input logic d, input logic [7:0] data);
    rst = r; en = e; pg_re = re; pg_addr = 5'(a); pg_check = c; pg_done = d;
    sd[0] = past[0];
    sd[1] = past[2];
    @(posedge clk);
    model_edge();
    past[2] = past[1]; past[1] = past[0]; past[0] = data;
    @(negedge clk);
  endtask

  task automatic zero_one(input int f);
    logic [7:0] c, data;
    step(1, 0, 0, 0, 8'h00, 0, 8'h00);
    chk_on = 1;
    step(0, 1, 0, 0, 8'h00, 0, 8'h00);
    for (int p = 0; p < 2; p++)
      for (int a = 0; a < 32; a++) begin
        c = p == 1 ? 8'hFF : 8'h00;
        data = c;
        if (p == 1) begin
          if (f == 1 && a == 5) data = data ^ 8'h01;
          if (f == 2 && (a == 3 || a == 17)) data = data & 8'h7F;
          if (f == 3) data = data ^ 8'h10;
          if (f == 4 && a == 31) data = data ^ 8'h40;
        end
        step(0, 1, 1, a, c, p == 1 && a == 31, data);
      end
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 1, int'($urandom_range(0, 31)), 8'hAA, 0, 8'h55);
      if (i == 0) begin
        chk("lit_done0_l1", int'(done0), 1);
        chk("lit_done1_early", int'(done1), 0);
      end
      if (i == 2) chk("lit_done1_l3", int'(done1), 1);
    end
  endtask

  initial begin
    logic [7:0] c, data;
    zero_one(0);
    chk("lit_clean_fail0", int'(fail0), 0);
    chk("lit_clean_err0", int'(err0), 0);
    chk("lit_clean_err1", int'(err1), 0);
    zero_one(1);
    chk("lit_flip_fail", int'(fail0), 1);
    chk("lit_flip_err", int'(err0), 1);
    chk("lit_flip_addr", int'(ffa0), 5);
    chk("lit_flip_exp", int'(ffe0), 'hFF);
    chk("lit_flip_act", int'(ffx0), 'hFE);
    zero_one(2);
    chk("lit_stuck_err", int'(err0), 2);
    chk("lit_stuck_addr", int'(ffa0), 3);
    chk("lit_stuck_act", int'(ffx0), 'h7F);
    zero_one(3);
    chk("lit_sat_err1", int'(err1), 'hF);
    chk("lit_all_err0", int'(err0), 32);
    zero_one(4);
    chk("lit_last_err1", int'(err1), 1);
    chk("lit_last_addr1", int'(ffa1), 31);
    chk("lit_last_done1", int'(done1), 1);
    step(1, 0, 0, 0, 8'h00, 0, 8'h00);
    step(0, 1, 0, 0, 8'h00, 0, 8'h00);
    step(0, 1, 1, 7, 8'hFF, 0, 8'h00);
    step(1, 0, 0, 0, 8'h00, 0, 8'h00);
    chk("lit_rst_err0", int'(err0), 0);
    chk("lit_rst_fail0", int'(fail0), 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 7, 8'hFF, 0, 8'h00);
    chk("lit_idle_err0", int'(err0), 0);
    chk("lit_idle_err1", int'(err1), 0);
    chk("lit_idle_done0", int'(done0), 0);
    for (int ep = 0; ep < 10; ep++) begin
      step(1, 0, 0, 0, 8'h00, 0, 8'h00);
      for (int cyc = 0; cyc < 120; cyc++) begin
        c = 8'($urandom);
        data = ($urandom % (ep < 5 ? 4 : 2) == 0) ? c ^ 8'($urandom_range(1, 255)) : c;
        step($urandom % 150 == 0, $urandom % 8 != 0, 1'($urandom), int'($urandom_range(0, 31)),
             c, cyc >= 60 && $urandom % 20 == 0, data);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bist_checker.md
BIST_CHECKER -- requirements
Module: bist_checker

Interface
REQ-001 Parameter MAX_ADDR, default 31, highest address the pattern generator drives.
REQ-002 Parameter DATA_WIDTH, default 8, SRAM word width.
REQ-003 Parameter READ_LATENCY, default 1 (legal 1..4), cycles from sampled read request to valid sram_dout.
REQ-004 Parameter ERR_CNT_WIDTH, default 16, width of the error counter.
REQ-005 Derived ADDR_WIDTH = $clog2(MAX_ADDR+1).
REQ-006 clk  input  1  sole clock; all state updates on posedge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 en  input  1  checker armed; same enable the pattern generator receives.
REQ-009 pg_re  input  1  generator read strobe.
REQ-010 pg_addr  input  ADDR_WIDTH  generator address.
REQ-011 pg_check  input  DATA_WIDTH  expected read data for pg_addr.
REQ-012 pg_done  input  1  generator finished all sequences.
REQ-013 sram_dout  input  DATA_WIDTH  SRAM read data.
REQ-014 done  output  1  checking complete, pipeline drained.
REQ-015 fail  output  1  at least one mismatch detected.
REQ-016 err_count  output  ERR_CNT_WIDTH  mismatch count, saturating.
REQ-017 first_fail_addr  output  ADDR_WIDTH  address of first mismatch.
REQ-018 first_fail_expected / first_fail_actual  output  DATA_WIDTH each  expected/read word of first mismatch.

Function
REQ-019 FSM states IDLE, RUN, DRAIN, DONE; reset state IDLE.
REQ-020 IDLE->RUN when en=1; RUN->DRAIN on the edge pg_done=1 is sampled; DRAIN->DONE after exactly READ_LATENCY further edges; DONE holds until rst.
REQ-021 In RUN only, edge t with pg_re=1 pushes {valid, pg_addr, pg_check} into a READ_LATENCY-deep delay line; pg_re ignored in IDLE, DRAIN, DONE.
REQ-022 At edge t+READ_LATENCY, delayed valid entry compared bitwise against sram_dout (RUN or DRAIN); non-valid slots never compared.
REQ-023 Mismatch: err_count increments at that edge, saturates at all-ones (no wrap).
REQ-024 First mismatch since reset: fail set, first_fail_* captured at same edge; later mismatches leave first_fail_* unchanged; fail sticky until rst.
REQ-025 Compare results registered: err_count/fail visible after edge t+READ_LATENCY, no combinational path from sram_dout to outputs.
REQ-026 pg_re and pg_done sampled together: that read is still pushed and checked during DRAIN.
REQ-027 en deasserted in RUN: pushes stall (no new entries), in-flight entries still checked, state unchanged.
REQ-028 done=1 only in DONE; pg_re in DONE has no effect.

Reset
REQ-029 rst=1 at an edge: state IDLE, delay line valids cleared (in-flight reads discarded, never counted), done=0, fail=0, err_count=0, first_fail_addr=0, first_fail_expected=0, first_fail_actual=0.
REQ-030 rst dominates all other inputs in the same cycle, including mid-RUN and mid-DRAIN.

Structure
REQ-031 Package bist_pkg holds the checker state enum and default constants (MAX_ADDR, DATA_WIDTH, READ_LATENCY, ERR_CNT_WIDTH) shared with pattern generators.
REQ-032 One sub-module bist_delay_line: parameterised depth/width shift register with synchronous clear, used for {valid, addr, expected}.

Verification
REQ-033 Defaults, zero_one_patgen driving, SRAM model exact -> done=1 READ_LATENCY+1 cycles after pg_done, fail=0, err_count=0.
REQ-034 SRAM model flips bit 0 on address 5 during read-1 pass -> fail=1, err_count=1, first_fail_addr=5, expected=8'hFF, actual=8'hFE.
REQ-035 Stuck-at-zero on address 3 and 17 bit 7 in read-1 pass -> err_count=2, first_fail_addr=3.
REQ-036 READ_LATENCY=3, error on last read (addr 31) coincident with pg_done -> counted in DRAIN, err_count=1, done asserted 3 edges after pg_done edge.
REQ-037 ERR_CNT_WIDTH=4, all 32 read-1 words wrong -> err_count=4'hF, no wrap.
REQ-038 rst pulsed one cycle while a mismatching read is in flight -> err_count=0, fail=0, state IDLE, error never counted.
